// File: rtl/int_to_float_pkg.sv
// Shared constants, the FP32 result layout and the index-width helper
// used by the integer-to-FP32 pipeline.
package int_to_float_pkg;

  localparam int FP32_BIAS = 127;
  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int STAGES    = 3;

  localparam logic RND_RNE = 1'b0;
  localparam logic RND_RTZ = 1'b1;

  typedef struct packed {
    logic             sgn;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp32_t;

  // Width of a leading-one index for an in_w-bit word.
  function automatic int idx_w(input int in_w);
    return (in_w <= 2) ? 1 : $clog2(in_w);
  endfunction

endpackage

// File: rtl/int_to_float_if.sv
// Valid/ready bundle between an integer producer, the converter and an
// FP32 consumer.
interface int_to_float_if #(
  parameter int IN_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            in_rnd;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_data;
  logic            out_inexact;

  modport master (
    output in_valid, in_data, in_rnd, out_ready,
    input  in_ready, out_valid, out_data, out_inexact
  );

  modport slave (
    input  in_valid, in_data, in_rnd, out_ready,
    output in_ready, out_valid, out_data, out_inexact
  );
endinterface

// File: rtl/int_to_float_lzc.sv
// Combinational leading-one detector: index of the highest set bit plus
// an all-zero flag.
module int_to_float_lzc
  import int_to_float_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int IDX_W = idx_w(IN_W)
) (
  input  logic [IN_W-1:0]  data,
  output logic [IDX_W-1:0] pos,
  output logic             zero
);

  // Scan upward so the highest set bit is the last one written.
  always_comb begin
    pos  = '0;
    zero = 1'b1;
    for (int i = 0; i < IN_W; i++) begin
      if (data[i]) begin
        pos  = IDX_W'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/int_to_float_pipe.sv
// Three-stage integer to FP32 converter: capture magnitude, normalise with
// guard/sticky, then round and pack. Elastic valid/ready between stages.
module int_to_float_pipe
  import int_to_float_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter bit SIGNED = 1'b1
) (
  input logic           clk,
  input logic           rst,
  int_to_float_if.slave io
);

  localparam int IDX_W = idx_w(IN_W);
  localparam int SIG_W = MAN_W + 1;
  localparam int PAD_W = MAN_W + 3;
  localparam int EXT_W = IN_W + PAD_W;

  logic [STAGES:1] vld_pipe;
  logic            rdy1, rdy2, rdy3;

  // Ready ripples back from the output; a full stage still loads when it drains.
  assign rdy3 = !vld_pipe[3] || io.out_ready;
  assign rdy2 = !vld_pipe[2] || rdy3;
  assign rdy1 = !vld_pipe[1] || rdy2;

  assign io.in_ready  = rdy1;
  assign io.out_valid = vld_pipe[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      if (rdy1) vld_pipe[1] <= io.in_valid;
      if (rdy2) vld_pipe[2] <= vld_pipe[1];
      if (rdy3) vld_pipe[3] <= vld_pipe[2];
    end
  end

  // ---------------- S1: sign / magnitude capture ----------------
  logic            in_neg;
  logic [IN_W-1:0] in_mag;

  logic            s1_sgn;
  logic [IN_W-1:0] s1_mag;
  logic            s1_rnd;
  logic            s1_zero;

  // Negating the most negative value wraps to 2^(IN_W-1), which is exactly
  // its magnitude when read as unsigned.
  assign in_neg = SIGNED && io.in_data[IN_W-1];
  assign in_mag = in_neg ? -io.in_data : io.in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sgn  <= 1'b0;
      s1_mag  <= '0;
      s1_rnd  <= RND_RNE;
      s1_zero <= 1'b1;
    end else if (rdy1 && io.in_valid) begin
      s1_sgn  <= in_neg;
      s1_mag  <= in_mag;
      s1_rnd  <= io.in_rnd;
      s1_zero <= (io.in_data == '0);
    end
  end

  // ---------------- S2: normalise ----------------
  logic [IDX_W-1:0] lzc_pos;
  logic             lzc_zero;
  logic [IDX_W-1:0] shamt;
  logic [IN_W-1:0]  norm;
  logic [EXT_W-1:0] ext;

  int_to_float_lzc #(
    .IN_W  (IN_W),
    .IDX_W (IDX_W)
  ) u_lzc (
    .data (s1_mag),
    .pos  (lzc_pos),
    .zero (lzc_zero)
  );

  assign shamt = IDX_W'(IN_W - 1) - lzc_pos;
  assign norm  = s1_mag << shamt;
  // Zero padding below the word keeps the 24-bit/G/S slice valid for narrow IN_W.
  assign ext   = {norm, {PAD_W{1'b0}}};

  logic             s2_sgn;
  logic [SIG_W-1:0] s2_man;
  logic             s2_g;
  logic             s2_s;
  logic [IDX_W-1:0] s2_pos;
  logic             s2_rnd;
  logic             s2_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_sgn  <= 1'b0;
      s2_man  <= '0;
      s2_g    <= 1'b0;
      s2_s    <= 1'b0;
      s2_pos  <= '0;
      s2_rnd  <= RND_RNE;
      s2_zero <= 1'b1;
    end else if (rdy2 && vld_pipe[1]) begin
      s2_sgn  <= s1_sgn;
      s2_man  <= ext[EXT_W-1 -: SIG_W];
      s2_g    <= ext[IN_W+1];
      s2_s    <= |ext[IN_W:0];
      s2_pos  <= lzc_pos;
      s2_rnd  <= s1_rnd;
      s2_zero <= s1_zero || lzc_zero;
    end
  end

  // ---------------- S3: round / pack ----------------
  logic             rnd_inc;
  logic [SIG_W-1:0] man_inc;
  logic             man_ovf;
  fp32_t            res;
  logic             res_inexact;

  assign rnd_inc = (s2_rnd == RND_RNE) && s2_g && (s2_s || s2_man[0]);
  assign man_inc = s2_man + SIG_W'(rnd_inc);
  // The hidden bit is set for any non-zero word, so losing it means carry-out.
  assign man_ovf = !s2_zero && !man_inc[SIG_W-1];

  always_comb begin
    res         = '0;
    res_inexact = 1'b0;
    if (!s2_zero) begin
      res.sgn     = s2_sgn;
      res.exp     = EXP_W'(FP32_BIAS) + EXP_W'(s2_pos) + EXP_W'(man_ovf);
      res.frac    = man_inc[MAN_W-1:0];
      res_inexact = s2_g || s2_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io.out_data    <= '0;
      io.out_inexact <= 1'b0;
    end else if (rdy3 && vld_pipe[2]) begin
      io.out_data    <= res;
      io.out_inexact <= res_inexact;
    end
  end

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Bench for int_to_float_pipe: signed and unsigned instances driven in
// lock-step, checked against an arithmetic rounding model.
module tb_int_to_float_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int_to_float_if #(.IN_W(32)) ifs ();
  int_to_float_if #(.IN_W(32)) ifu ();

  int_to_float_pipe #(.IN_W(32), .SIGNED(1'b1)) u_dut_s (.clk(clk), .rst(rst), .io(ifs));
  int_to_float_pipe #(.IN_W(32), .SIGNED(1'b0)) u_dut_u (.clk(clk), .rst(rst), .io(ifu));

  typedef struct packed {
    logic [32:0] r;
    logic [31:0] cyc;
  } exp_t;

  exp_t        q [2][$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  bit          chk_lat = 1'b0;
  bit          hold_v [2];
  logic [32:0] hold_r [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {inexact, fp32}: exact value split into a 24-bit mantissa and remainder.
  function automatic logic [32:0] model(input logic [31:0] d, input bit sgnd, input bit rtz);
    longint unsigned mag, m, rem, half;
    bit neg, inx;
    int p, e;
    neg = sgnd && d[31];
    mag = neg ? (64'h1_0000_0000 - {32'b0, d}) : {32'b0, d};
    if (mag == 0) return 33'h0;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    if (p <= 23) begin
      m = mag << (23 - p);
      rem = 0;
    end else begin
      m = mag >> (p - 23);
      rem = mag - (m << (p - 23));
    end
    inx = (rem != 0);
    if (!rtz && p > 23) begin
      half = 64'd1 << (p - 24);
      if (rem > half || (rem == half && m[0])) m++;
    end
    e = 127 + p;
    if (m == (64'd1 << 24)) begin
      m = m >> 1;
      e++;
    end
    return {inx, neg, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] d;
    d = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) d = -d;
    if ($urandom_range(0, 15) == 0) d = 32'h0;
    return d;
  endfunction

  task automatic mon(input int id, input bit push, input logic [32:0] e,
                     input bit ov, input logic [32:0] o, input bit ordy);
    exp_t x;
    if (hold_v[id]) begin
      chk($sformatf("hold_valid[%0d]", id), 64'(ov), 64'd1);
      chk($sformatf("hold_data[%0d]", id), 64'(o), 64'(hold_r[id]));
    end
    if (push) begin
      x.r = e;
      x.cyc = cyc;
      q[id].push_back(x);
    end
    if (ov && ordy) begin
      if (q[id].size() == 0) begin
        chk($sformatf("unexpected_out_valid[%0d]", id), 64'(ov), 64'd0);
      end else begin
        x = q[id].pop_front();
        chk($sformatf("out_data[%0d]", id), 64'(o[31:0]), 64'(x.r[31:0]));
        chk($sformatf("out_inexact[%0d]", id), 64'(o[32]), 64'(x.r[32]));
        if (chk_lat) chk($sformatf("latency[%0d]", id), 64'(cyc - int'(x.cyc)), 64'd3);
      end
    end
    hold_v[id] = ov && !ordy;
    hold_r[id] = o;
  endtask

  // One clock cycle: drive at the falling edge, observe shortly after.
  task automatic step(input bit v, input logic [31:0] d, input bit r, input bit ordy,
                      input bit lit, input logic [32:0] ls, input logic [32:0] lu,
                      output bit took);
    logic [32:0] es, eu;
    @(negedge clk);
    cyc++;
    ifs.in_valid = v; ifs.in_data = d; ifs.in_rnd = r; ifs.out_ready = ordy;
    ifu.in_valid = v; ifu.in_data = d; ifu.in_rnd = r; ifu.out_ready = ordy;
    #1;
    took = v && ifs.in_ready;
    es = lit ? ls : model(d, 1'b1, r);
    eu = lit ? lu : model(d, 1'b0, r);
    mon(0, v && ifs.in_ready, es, ifs.out_valid, {ifs.out_inexact, ifs.out_data}, ordy);
    mon(1, v && ifu.in_ready, eu, ifu.out_valid, {ifu.out_inexact, ifu.out_data}, ordy);
  endtask

  task automatic drain(input bit rnd_rdy);
    bit t;
    for (int i = 0; i < 200 && (q[0].size() + q[1].size()) != 0; i++)
      step(1'b0, 32'h0, 1'b0, rnd_rdy ? 1'(($urandom_range(0, 1))) : 1'b1, 1'b0, 33'h0, 33'h0, t);
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 33'h0, 33'h0, t);
    chk("drain_empty", 64'(q[0].size() + q[1].size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] dv [9];
  logic        rv [9];
  logic [32:0] ls [9];
  logic [32:0] lu [9];

  initial begin
    bit          took;
    int          acc;
    logic [31:0] cur_d;
    logic        cur_r;

    dv = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h01000001,
           32'h01000003, 32'h01FFFFFF, 32'h01FFFFFF, 32'hFFFFFFFF};
    rv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ls = '{{1'b0, 32'h00000000}, {1'b0, 32'h3F800000}, {1'b0, 32'hBF800000},
           {1'b0, 32'hCF000000}, {1'b1, 32'h4B800000}, {1'b1, 32'h4B800002},
           {1'b1, 32'h4C000000}, {1'b1, 32'h4BFFFFFF}, {1'b0, 32'hBF800000}};
    lu = '{{1'b0, 32'h00000000}, {1'b0, 32'h3F800000}, {1'b1, 32'h4F800000},
           {1'b0, 32'h4F000000}, {1'b1, 32'h4B800000}, {1'b1, 32'h4B800002},
           {1'b1, 32'h4C000000}, {1'b1, 32'h4BFFFFFF}, {1'b1, 32'h4F7FFFFF}};

    ifs.in_valid = 0; ifs.in_data = 0; ifs.in_rnd = 0; ifs.out_ready = 1;
    ifu.in_valid = 0; ifu.in_data = 0; ifu.in_rnd = 0; ifu.out_ready = 1;
    hold_v[0] = 0; hold_v[1] = 0;
    hold_r[0] = '0; hold_r[1] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(ifs.out_valid), 64'd0);
    chk("rst_out_data", 64'(ifs.out_data), 64'd0);
    chk("rst_out_inexact", 64'(ifs.out_inexact), 64'd0);
    chk("rst_out_valid_u", 64'(ifu.out_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(ifs.in_ready), 64'd1);

    // Directed vectors back-to-back, full throughput, latency checked
    chk_lat = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, dv[i], rv[i], 1'b1, 1'b1, ls[i], lu[i], took);
      chk($sformatf("dir_accept[%0d]", i), 64'(took), 64'd1);
    end
    drain(1'b0);

    // Back-pressure: fill while stalled, then random out_ready until 10 words
    chk_lat = 1'b0;
    acc = 0;
    cur_d = rnd_word();
    cur_r = 1'($urandom_range(0, 1));
    repeat (5) begin
      step(1'b1, cur_d, cur_r, 1'b0, 1'b0, 33'h0, 33'h0, took);
      if (took) begin
        acc++;
        cur_d = rnd_word();
        cur_r = 1'($urandom_range(0, 1));
      end
    end
    chk("stall_accepted", 64'(acc), 64'd3);
    chk("stall_in_ready", 64'(ifs.in_ready), 64'd0);
    for (int i = 0; i < 500 && acc < 10; i++) begin
      step(1'b1, cur_d, cur_r, 1'($urandom_range(0, 1)), 1'b0, 33'h0, 33'h0, took);
      if (took) begin
        acc++;
        cur_d = rnd_word();
        cur_r = 1'($urandom_range(0, 1));
      end
    end
    chk("bp_words_sent", 64'(acc), 64'd10);
    drain(1'b1);

    // Longer random traffic on both sides
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), rnd_word(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'b0, 33'h0, 33'h0, took);
    drain(1'b0);

    // Asynchronous reset with a full pipeline
    repeat (3) step(1'b1, rnd_word(), 1'b0, 1'b0, 1'b0, 33'h0, 33'h0, took);
    @(negedge clk);
    ifs.in_valid = 0; ifu.in_valid = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(ifs.out_valid), 64'd0);
    chk("async_rst_out_valid_u", 64'(ifu.out_valid), 64'd0);
    q[0].delete(); q[1].delete();
    hold_v[0] = 0; hold_v[1] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(ifs.in_ready), 64'd1);
    repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 33'h0, 33'h0, took);
    chk_lat = 1'b1;
    step(1'b1, 32'hFFFFFF9C, 1'b0, 1'b1, 1'b1, {1'b0, 32'hC2C80000}, {1'b1, 32'h4F800000}, took);
    chk("post_rst_accept", 64'(took), 64'd1);
    drain(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/int_to_float_pipe.md
# int_to_float_pipe

Pipelined, parametrised integer-to-IEEE-754 single-precision converter with valid/ready flow control. It accepts signed or unsigned integers of configurable width and selectable rounding, and reports inexact results. It is the throughput-oriented successor to the single-cycle converter and sits between integer datapaths (counters, ADC accumulators) and the FP32 arithmetic units.

## Interface
- IN_W, 32, integer input width; legal range 8..64.
- SIGNED, 1, 1: input is two's complement; 0: input is unsigned.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high. Clears all pipeline state.
- in_valid  in  1  input word present.
- in_ready  out  1  converter accepts the word this cycle.
- in_data  in  IN_W  integer operand.
- in_rnd  in  1  rounding mode for this word: 0 round-to-nearest-even (RNE), 1 round-toward-zero (RTZ).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  32  FP32 result {sign, exp[7:0], frac[22:0]}.
- out_inexact  out  1  result differs from the exact integer value.

## Operation
- Transfer on a port occurs when valid && ready are both high on a rising edge.
- Stage S1 (capture): register the sign. Sign is in_data[IN_W-1] when SIGNED, else 0. Register the magnitude |in_data| as an IN_W-bit unsigned value; the most negative input maps to 2^(IN_W-1). Register in_rnd and a zero flag.
- Stage S2 (normalise): the leading-one position p (0..IN_W-1) comes from the LZC. Left-shift the magnitude so bit p lands at the MSB. Carry the top 24 bits (hidden bit plus 23 fraction bits), guard bit G, and sticky bit S (OR of all remaining lower bits).
- Stage S3 (round/pack): RNE increments the mantissa when G && (S || mantissa LSB). RTZ never increments. If the increment overflows the 24-bit mantissa, set frac to 0 and use exponent p+1. Exponent field is 127+p, or 127+p+1 on overflow. out_inexact = G || S.
- Zero input gives out_data = 0x00000000 (+0) and out_inexact = 0, regardless of sign or mode.
- When p ≤ 23, G and S are 0: the result is exact in both modes.
- No overflow or infinity is possible: the maximum exponent field is 127+64 = 191.

## Timing
- Latency: 3 cycles from input transfer to out_valid, with no back-pressure.
- Throughput: 1 word per cycle while out_ready = 1.
- Each stage holds a valid bit. A stage loads when it is empty, or when its contents advance in the same cycle.
- in_ready = !s1_valid || s1_advance, where s1_advance = s2 can accept. The chain continues from out_ready. Combinational ready path is permitted.
- Back-pressure: while out_valid && !out_ready, out_data and out_inexact are held stable. The pipeline fills (up to 3 words) and then in_ready drops.
- A transfer in and a transfer out in the same cycle is legal at full occupancy, with no bubble.
- Reset values: out_valid = 0, out_data = 0, out_inexact = 0, all stage valids = 0. in_ready = 1 after reset release.
- Reset asserted mid-operation discards all in-flight words. No partial result is emitted after reset.

## Structure
- Package int_to_float_pkg holds:
  - FP32_BIAS = 127, EXP_W = 8, MAN_W = 23.
  - Rounding-mode constants RND_RNE = 0 and RND_RTZ = 1.
  - A function computing the leading-one index width, clog2(IN_W).
- Sub-module int_to_float_lzc: a combinational leading-one detector parametrised by IN_W. It outputs p and an all-zero flag, and is instantiated in S2.
- The top level contains the three stage registers and the shared handshake logic.

## Test plan
- IN_W = 32, SIGNED = 1, RNE, inputs 0, 1, -1 back-to-back, out_ready = 1 -> 0x00000000, 0x3F800000, 0xBF800000 on three consecutive cycles starting 3 cycles after the first transfer; inexact = 0.
- Input 0x80000000 (most negative) -> 0xCF000000, inexact = 0. With SIGNED = 0, the same bits -> 0x4F000000.
- RNE ties:
  - 0x01000001 -> 0x4B800000 (tie to even, down), inexact = 1.
  - 0x01000003 -> 0x4B800002 (tie to even, up), inexact = 1.
- Mantissa overflow: 0x01FFFFFF with RNE -> 0x4C000000, inexact = 1. With RTZ -> 0x4BFFFFFF, inexact = 1.
- Back-pressure: stream 10 random words with out_ready toggling pseudo-randomly. Results must be in order, bit-exact against the reference model, with no drops or duplicates, and out_data stable while stalled. in_ready must drop after 3 stalled words.
- Assert rst with 3 words in flight -> out_valid = 0 within the same cycle (async). No stale word appears after release, and the next input produces the correct result at latency 3.
